// File: rtl/aia_irq_src_gen.sv
// aia_irq_src_gen -- programmable AIA interrupt source generator.
//
// Produces NR_SRC interrupt lines shaped for APLIC source inputs. Each source
// has its own sourcemode and pulse-length registers and a small FSM
// (IDLE -> ASSERT -> GAP -> IDLE) that turns accepted requests into either
// fixed-length edge pulses or level assertions held until cleared.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-high reset
//   cfg_we_i     configuration write strobe
//   cfg_idx_i    source index targeted by the write (out-of-range ignored)
//   cfg_mode_i   AIA sourcemode (0 Inactive, 1 Detached, 4/5 Edge1/0,
//                6/7 Level1/0; 2/3 behave as Inactive)
//   cfg_len_i    edge pulse length minus one
//   req_valid_i  per-source interrupt request
//   req_ready_o  per-source request accept (combinational)
//   clr_i        per-source level deassert (service complete)
//   irq_o        registered interrupt lines
//   busy_o       per-source FSM not IDLE
module aia_irq_src_gen #(
  parameter int unsigned NR_SRC = 4,
  parameter int unsigned LEN_W  = 4,
  localparam int unsigned IDX_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic [2:0]        cfg_mode_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic [NR_SRC-1:0] req_valid_i,
  output logic [NR_SRC-1:0] req_ready_o,
  input  logic [NR_SRC-1:0] clr_i,
  output logic [NR_SRC-1:0] irq_o,
  output logic [NR_SRC-1:0] busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  function automatic logic is_detached(input logic [2:0] m);
    return m == 3'd1;
  endfunction

  function automatic logic is_edge(input logic [2:0] m);
    return (m == 3'd4) || (m == 3'd5);
  endfunction

  function automatic logic is_level(input logic [2:0] m);
    return (m == 3'd6) || (m == 3'd7);
  endfunction

  // Inverted-polarity modes (Edge0, Level0) rest high; everything else,
  // including Inactive, Detached and the reserved codes, rests low.
  function automatic logic idle_lvl(input logic [2:0] m);
    return (m == 3'd5) || (m == 3'd7);
  endfunction

  for (genvar i = 0; i < NR_SRC; i++) begin : g_src
    logic [2:0]       mode_q, mode_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    state_e           st_q, st_d;
    logic             irq_q, irq_d;
    logic             cfg_hit;
    logic             ready;
    logic             accept;

    // Only in-range indices can ever match, so out-of-range writes fall away.
    assign cfg_hit = cfg_we_i && (cfg_idx_i == IDX_W'(i));

    // A write to this source blocks acceptance for that cycle so a request
    // never races a mode/length change.
    assign ready  = (st_q == ST_IDLE) && !cfg_hit &&
                    (is_detached(mode_q) || is_edge(mode_q) || is_level(mode_q));
    assign accept = ready && req_valid_i[i];

    always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it
      // unassigned -- that is what keeps this block free of inferred latches.
      mode_d = mode_q;
      len_d  = len_q;
      cnt_d  = cnt_q;
      st_d   = st_q;

      unique case (st_q)
        ST_IDLE: begin
          // Detached accepts and drops the request: nothing changes.
          if (accept && is_edge(mode_q)) begin
            st_d  = ST_ASSERT;
            cnt_d = len_q;
          end else if (accept && is_level(mode_q)) begin
            st_d = ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (is_edge(mode_q)) begin
            // Counter holds remaining cycles minus one; stops at zero.
            if (cnt_q == '0) st_d = ST_GAP;
            else             cnt_d = cnt_q - LEN_W'(1);
          end else if (clr_i[i]) begin
            st_d = ST_GAP;
          end
        end
        ST_GAP:  st_d = ST_IDLE;
        default: st_d = ST_IDLE;
      endcase

      // A mode change aborts whatever is in flight with no GAP; a same-mode
      // write only retargets the length for the next acceptance.
      if (cfg_hit) begin
        len_d = cfg_len_i;
        if (cfg_mode_i != mode_q) begin
          mode_d = cfg_mode_i;
          st_d   = ST_IDLE;
        end
      end

      irq_d = (st_d == ST_ASSERT) ? ~idle_lvl(mode_d) : idle_lvl(mode_d);
    end

    // NOTE: all per-source registers are reset -- there are only a handful
    // of bits each and the line level must be defined the moment reset hits.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        mode_q <= 3'd0;
        len_q  <= '0;
        cnt_q  <= '0;
        st_q   <= ST_IDLE;
        irq_q  <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        mode_q <= mode_d;
        len_q  <= len_d;
        cnt_q  <= cnt_d;
        st_q   <= st_d;
        irq_q  <= irq_d;
      end
    end

    assign req_ready_o[i] = ready;
    assign irq_o[i]       = irq_q;
    assign busy_o[i]      = (st_q != ST_IDLE);
  end

endmodule

// File: tb/tb_aia_irq_src_gen.sv
// Bench for aia_irq_src_gen: a timeline model (per source: pulse window and
// busy-until cycle, computed from acceptance times) compared on every
// falling edge, plus directed sequences with hand-computed expectations.
module tb_aia_irq_src_gen;
  localparam int NR = 4;
  localparam int LW = 4;
  localparam int INF = 32'h3fffffff;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_idx = '0;
  logic [2:0]    cfg_mode = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] clr = '0;
  logic [NR-1:0] ready, irq, busy;

  int total = 0;
  int bad   = 0;

  aia_irq_src_gen #(.NR_SRC(NR), .LEN_W(LW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_we_i    (cfg_we),
    .cfg_idx_i   (cfg_idx),
    .cfg_mode_i  (cfg_mode),
    .cfg_len_i   (cfg_len),
    .req_valid_i (req),
    .req_ready_o (ready),
    .clr_i       (clr),
    .irq_o       (irq),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  logic [2:0] m_mode[NR] = '{default: 3'd0};
  int         m_len [NR] = '{default: 0};
  int         m_lo  [NR] = '{default: 1};
  int         m_hi  [NR] = '{default: 0};
  int         m_free[NR] = '{default: 0};
  int         cyc = 0;

  always @(negedge clk) begin : model
    logic [NR-1:0] e_irq, e_busy, e_rdy;
    logic in_a, hit, acc, idl, vld;
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_mode[i] = 3'd0; m_len[i] = 0; m_lo[i] = 1; m_hi[i] = 0; m_free[i] = 0;
      end
    end
    for (int i = 0; i < NR; i++) begin
      in_a      = (cyc >= m_lo[i]) && (cyc <= m_hi[i]);
      idl       = (m_mode[i] == 3'd5) || (m_mode[i] == 3'd7);
      vld       = (m_mode[i] == 3'd1) || (m_mode[i] >= 3'd4);
      hit       = cfg_we && (int'(cfg_idx) == i);
      e_busy[i] = cyc < m_free[i];
      e_irq[i]  = in_a ? ~idl : idl;
      e_rdy[i]  = !e_busy[i] && vld && !hit;
    end
    check("cmp_irq",   irq,   e_irq);
    check("cmp_busy",  busy,  e_busy);
    check("cmp_ready", ready, e_rdy);
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        in_a = (cyc >= m_lo[i]) && (cyc <= m_hi[i]);
        hit  = cfg_we && (int'(cfg_idx) == i);
        acc  = e_rdy[i] && req[i];
        if (acc && (m_mode[i] == 3'd4 || m_mode[i] == 3'd5)) begin
          m_lo[i] = cyc + 1; m_hi[i] = cyc + 1 + m_len[i]; m_free[i] = cyc + m_len[i] + 3;
        end else if (acc && m_mode[i] >= 3'd6) begin
          m_lo[i] = cyc + 1; m_hi[i] = INF; m_free[i] = INF;
        end else if (m_mode[i] >= 3'd6 && in_a && clr[i]) begin
          m_hi[i] = cyc; m_free[i] = cyc + 2;
        end
        if (hit) begin
          m_len[i] = int'(cfg_len);
          if (cfg_mode != m_mode[i]) begin
            m_mode[i] = cfg_mode; m_lo[i] = 1; m_hi[i] = 0; m_free[i] = cyc + 1;
          end
        end
      end
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [2:0] mode, input logic [LW-1:0] len);
    cfg_we = 1'b1; cfg_idx = idx; cfg_mode = mode; cfg_len = len;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin : stim
    logic [5:0] seq;
    int hi_cnt;

    repeat (2) tick();
    req = '1;
    #1;
    check("rst_irq",   irq,   4'b0000);
    check("rst_busy",  busy,  4'b0000);
    check("rst_ready", ready, 4'b0000);
    req = '0;
    #1 rst = 1'b0;
    tick();

    cfg(2'd0, 3'd4, 4'd2);
    cfg(2'd1, 3'd5, 4'd0);
    check("edge0_idle_high", irq[1], 1'b1);
    cfg(2'd3, 3'd1, 4'd0);

    // Detached (src3) vs Inactive (src2) with requests held
    req = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("detached_ready", ready[3], 1'b1);
      check("inactive_ready", ready[2], 1'b0);
      check("det_inact_irq",  irq[3:2], 2'b00);
      tick();
    end
    req = '0;

    // Edge1 len=2: three high cycles, one GAP, then ready again
    req[0] = 1'b1;
    #1 check("edge1_ready_n", ready[0], 1'b1);
    tick();
    req[0] = 1'b0;
    clr[0] = 1'b1;   // ignored in Edge mode
    for (int k = 0; k < 3; k++) begin
      check("edge1_high", irq[0], 1'b1);
      tick();
    end
    clr[0] = 1'b0;
    check("edge1_gap_irq",   irq[0],   1'b0);
    check("edge1_gap_busy",  busy[0],  1'b1);
    check("edge1_gap_ready", ready[0], 1'b0);
    tick();
    check("edge1_ready_again", ready[0], 1'b1);
    check("edge1_idle_busy",   busy[0],  1'b0);

    // Edge0 len=0 with request held: single low cycles, two high between
    req[1] = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      seq[k] = irq[1];
      tick();
    end
    req[1] = 1'b0;
    check("edge0_seq", seq, 6'b110110);
    repeat (3) tick();

    // Level1 on src2: request at N, clear at N+15
    cfg(2'd2, 3'd6, 4'd0);
    req[2] = 1'b1;
    tick();
    req[2] = 1'b0;
    for (int k = 1; k < 15; k++) begin
      check("level1_high", irq[2], 1'b1);
      tick();
    end
    check("level1_high_clr_cycle", irq[2], 1'b1);
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    check("level1_low_after_clr", irq[2], 1'b0);
    check("level1_gap_busy",      busy[2], 1'b1);
    tick();
    check("level1_busy_low", busy[2], 1'b0);

    // Level0 in ASSERT, then switched to Edge1: immediate IDLE, no GAP
    cfg(2'd2, 3'd7, 4'd0);
    check("level0_idle_high", irq[2], 1'b1);
    req[2] = 1'b1;
    tick();
    req[2] = 1'b0;
    check("level0_assert_low", irq[2],  1'b0);
    check("level0_busy",       busy[2], 1'b1);
    tick();
    cfg(2'd2, 3'd4, 4'd0);
    #1;
    check("modechg_busy",  busy[2],  1'b0);
    check("modechg_irq",   irq[2],   1'b0);
    check("modechg_ready", ready[2], 1'b1);

    // Same-mode write blocks ready that cycle; max length gives 16 cycles;
    // a mid-pulse length rewrite does not shorten the pulse.
    req[0] = 1'b1;
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_mode = 3'd4; cfg_len = 4'd15;
    #1 check("cfg_blocks_ready", ready[0], 1'b0);
    tick();
    cfg_we = 1'b0;
    #1 check("ready_after_cfg", ready[0], 1'b1);
    tick();
    req[0] = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 22; k++) begin
      if (k == 3) begin
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_mode = 3'd4; cfg_len = 4'd1;
      end
      if (k == 4) cfg_we = 1'b0;
      hi_cnt += int'(irq[0]);
      tick();
    end
    check("maxlen_pulse_cycles", hi_cnt, 16);

    // Asynchronous reset in the middle of an Edge pulse
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    check("pre_rst_pulse", irq[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_irq",  irq,  4'b0000);
    check("async_rst_busy", busy, 4'b0000);
    tick();
    tick();
    #1 rst = 1'b0;
    req = '1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post_rst_irq",   irq,   4'b0000);
      check("post_rst_ready", ready, 4'b0000);
    end
    req = '0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
